sort_oet_seq: RTL
=================

Name: sort_oet_seq

Overview:
- Parametrised, iterative successor to the fixed 8-input combinational sorter. Sorts N words of W bits using odd-even transposition, one phase per clock.
- Sort direction is selectable per job. Signed or unsigned compare is set at build time.
- valid/ready handshakes on both sides, so it sits in a streaming datapath between a producer and a consumer.
- Trades the combinational depth of a full in-cycle sort for fixed N-cycle latency.

Parameters:
- N, 8, number of elements per job; legal range 2..64.
- W, 8, element width in bits.
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a job on in_data.
- in_ready  output  1  block can accept a job this cycle.
- in_data  input  N*W  element i occupies bits [i*W +: W].
- descend  input  1  sampled with the job: 1 = largest value at element 0, 0 = smallest value at element 0.
- out_valid  output  1  out_data holds a sorted job.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  N*W  sorted elements, same packing as in_data.
- busy  output  1  high while in SORT.

Behaviour:
- Reset, checked at the rising edge:
  - state = IDLE, phase counter = 0, data registers = 0, direction register = 0.
  - Outputs: out_valid = 0, busy = 0, out_data = 0, in_ready = 1 from the first cycle after reset.
- Reset mid-operation: the job in flight is discarded. No out_valid pulse appears for it.
- States:
  - IDLE: in_ready = 1. When in_valid is high, load in_data and descend, clear the phase counter, go to SORT.
  - SORT: in_ready = 0, busy = 1. Execute one phase per cycle, increment the phase counter. After the phase with index N-1, go to DONE.
  - DONE: out_valid = 1 and out_data are held stable until out_ready is high.
    - out_ready high, in_valid low: go to IDLE.
    - out_ready high, in_valid high: load the new job and go directly to SORT (back-to-back).
    - in_ready = out_ready in DONE. This is combinational from out_ready; no other path from inputs to outputs is combinational.
- Phases:
  - Even phase index p compares pairs (0,1), (2,3), ...
  - Odd phase index compares pairs (1,2), (3,4), ...
  - For odd N, the unpaired end element passes through unchanged.
- Compare-exchange for pair (k, k+1):
  - descend = 1: swap iff e[k] < e[k+1].
  - descend = 0: swap iff e[k] > e[k+1].
  - Comparison is strict, so equal elements never swap. The sort is stable.
  - SIGNED selects a signed or unsigned compare. No width growth; elements move unmodified.
- Latency and throughput:
  - Accept edge at cycle t; N phase edges follow; out_valid rises after edge t+N.
  - Sustained throughput: one job per N+1 cycles with out_ready tied high.
- The phase count is always N; there is no early exit. Latency does not depend on the data.
- Protocol:
  - in_valid high while in_ready is low: ignored, no load. The producer must hold its data.
  - The descend value latched at accept applies to the whole job. Changes to descend during SORT have no effect.
  - out_data stays unchanged while out_valid is high and out_ready is low.
- Phase counter width is $clog2(N+1). Compare logic is N/2 comparators, shared between even and odd phases.

Test Plan:
- N=8, W=8, SIGNED=0, descend=1, in = {3,250,7,7,0,128,1,255} (element 0 first) -> out = {255,250,128,7,7,3,1,0}; out_valid rises exactly 8 cycles after the accept edge; busy is high for 8 cycles.
- Same input with descend=0 -> out = {0,1,3,7,7,128,250,255}. Toggling descend during SORT does not change the result.
- SIGNED=1, W=8, N=5, descend=0, in = {0x7F,0x80,0xFF,0x00,0x01} -> out = {0x80,0xFF,0x00,0x01,0x7F}; the unpaired element is handled correctly for odd N.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data stable, in_ready=0. Then raise out_ready and in_valid together with job B -> A completes, B is loaded that cycle, B's out_valid rises 8 cycles later.
- Assert rst for 1 cycle during phase 3 -> out_valid stays 0, out_data=0, in_ready=1 on the next cycle. A new job then sorts correctly.
- Random regression: 10k jobs, N in {2,3,8,16}, random descend -> out_data matches a reference stable sort; out_valid is never asserted with unsorted data.

Source files
------------

// File: rtl/sort_oet_seq.sv
// ============================================================================
// sort_oet_seq : iterative odd-even transposition sorter, one phase per clock
// Rev 1.0
// ============================================================================
`default_nettype none

module sort_oet_seq #(
  parameter int N      = 8,
  parameter int W      = 8,
  parameter int SIGNED = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           descend,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic           busy
);

  localparam int PW = $clog2(N + 1);
  localparam int NP = N / 2;
  localparam logic [PW-1:0] LAST_PHASE = PW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [N*W-1:0]   data_q, data_d;
  logic             desc_q, desc_d;

  logic             odd_phase;
  logic [NP-1:0][W-1:0] lo_new;
  logic [NP-1:0][W-1:0] hi_new;
  logic [N*W-1:0]   phase_data;

  assign odd_phase = phase_q[0];

  // Comparator j serves pair (2j,2j+1) on even phases and (2j+1,2j+2) on odd ones.
  for (genvar j = 0; j < NP; j++) begin : g_cmp
    logic [W-1:0] a, b;
    logic         a_gt_b, a_lt_b, pair_en, do_swap;

    if (2*j + 2 < N) begin : g_shared
      assign a       = odd_phase ? data_q[(2*j+1)*W +: W] : data_q[(2*j)*W +: W];
      assign b       = odd_phase ? data_q[(2*j+2)*W +: W] : data_q[(2*j+1)*W +: W];
      assign pair_en = 1'b1;
    end else begin : g_even_only
      assign a       = data_q[(2*j)*W +: W];
      assign b       = data_q[(2*j+1)*W +: W];
      assign pair_en = ~odd_phase;
    end

    if (SIGNED != 0) begin : g_signed
      assign a_gt_b = $signed(a) > $signed(b);
      assign a_lt_b = $signed(a) < $signed(b);
    end else begin : g_unsigned
      assign a_gt_b = a > b;
      assign a_lt_b = a < b;
    end

    assign do_swap   = pair_en & (desc_q ? a_lt_b : a_gt_b);
    assign lo_new[j] = do_swap ? b : a;
    assign hi_new[j] = do_swap ? a : b;
  end

  // Route each element from its comparator for the current phase parity.
  for (genvar i = 0; i < N; i++) begin : g_elem
    logic [W-1:0] ev, od;

    if (i % 2 == 0) begin : g_ev_even
      if (i + 1 < N) begin : g_pair
        assign ev = lo_new[i/2];
      end else begin : g_pass
        assign ev = data_q[i*W +: W];
      end
    end else begin : g_ev_odd
      assign ev = hi_new[(i-1)/2];
    end

    if (i == 0) begin : g_od_first
      assign od = data_q[i*W +: W];
    end else if (i % 2 == 1) begin : g_od_odd
      if (i + 1 < N) begin : g_pair
        assign od = lo_new[(i-1)/2];
      end else begin : g_pass
        assign od = data_q[i*W +: W];
      end
    end else begin : g_od_even
      assign od = hi_new[(i-2)/2];
    end

    assign phase_data[i*W +: W] = odd_phase ? od : ev;
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    data_d    = data_q;
    desc_d    = desc_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          desc_d  = descend;
          phase_d = '0;
          state_d = SORT;
        end
      end
      SORT: begin
        busy    = 1'b1;
        data_d  = phase_data;
        phase_d = phase_q + PW'(1);
        if (phase_q == LAST_PHASE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            data_d  = in_data;
            desc_d  = descend;
            phase_d = '0;
            state_d = SORT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      data_q  <= '0;
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      desc_q  <= desc_d;
    end
  end

  assign out_data = data_q;

endmodule

`default_nettype wire
